// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-back data cache.
// Address split (byte address, 16 bits at defaults):
//   [0]      byte select, must be 0 (16-bit words)
//   [2:1]    word offset inside the line
//   [7:3]    line index
//   [15:8]   tag
// Helpers below take the word address (byte address without bit 0).
package dcache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int IDX_BITS   = 5;
    localparam int OFF_BITS   = $clog2(LINE_WORDS);
    localparam int WADDR_W    = ADDR_W - 1;
    localparam int TAG_BITS   = WADDR_W - IDX_BITS - OFF_BITS;
    localparam int NUM_LINES  = 1 << IDX_BITS;
    localparam int CNT_W      = OFF_BITS + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WB    = 3'd1;
    localparam logic [2:0] ST_ALLOC = 3'd2;
    localparam logic [2:0] ST_FILL  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Request captured at the start of a miss.
    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
    } req_t;

    function automatic logic [TAG_BITS-1:0] wa_tag(input logic [WADDR_W-1:0] wa);
        return wa[WADDR_W-1 -: TAG_BITS];
    endfunction

    function automatic logic [IDX_BITS-1:0] wa_idx(input logic [WADDR_W-1:0] wa);
        return wa[OFF_BITS +: IDX_BITS];
    endfunction

    function automatic logic [OFF_BITS-1:0] wa_off(input logic [WADDR_W-1:0] wa);
        return wa[OFF_BITS-1:0];
    endfunction

    // Byte address of one word of a line, as presented to main memory.
    function automatic logic [ADDR_W-1:0] line_word_addr(input logic [TAG_BITS-1:0] tag,
                                                         input logic [IDX_BITS-1:0] idx,
                                                         input logic [OFF_BITS-1:0] off);
        return {tag, idx, off, 1'b0};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag / valid / dirty / data storage for the data cache.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset (clears valid/dirty only)
//   i_rd_idx, i_rd_off      combinational read port: line index and word offset
//   o_rd_data               selected data word
//   o_rd_tag/valid/dirty    metadata of the selected line
//   i_wr_idx, i_wr_off      write port address (shared by data and metadata)
//   i_wr_data, i_wr_data_en data word write
//   i_wr_meta_en            metadata write of i_wr_tag / i_wr_valid / i_wr_dirty
module dcache_array
    import dcache_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    input  logic [OFF_BITS-1:0] i_rd_off,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic [TAG_BITS-1:0] o_rd_tag,
    output logic                o_rd_valid,
    output logic                o_rd_dirty,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic [OFF_BITS-1:0] i_wr_off,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_wr_data_en,
    input  logic                i_wr_meta_en,
    input  logic [TAG_BITS-1:0] i_wr_tag,
    input  logic                i_wr_valid,
    input  logic                i_wr_dirty
);

    logic [DATA_W-1:0]    r_data [NUM_LINES*LINE_WORDS];
    logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    // Data and tag storage: written on demand, never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_data_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_wr_meta_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    // Valid/dirty bits: cleared by reset, otherwise follow metadata writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_meta_en) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; misses write back a dirty victim (WB),
// fetch the line (ALLOC/FILL) and complete one cycle later (DONE).
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_rd/i_req_wr             load/store request, held until o_req_done
//   i_req_addr/i_req_wdata        byte address (even) and store data
//   o_req_rdata                   load data, valid with o_req_done
//   o_req_done/o_req_stall        completion pulse / miss in progress
//   o_cache_hit/o_err             qualifiers of o_req_done
//   o_mem_rd/o_mem_wr             word request to main memory
//   o_mem_addr/o_mem_wdata        memory byte address and write data
//   i_mem_stall                   memory refuses the request this cycle
//   i_mem_rdata/i_mem_rvalid      in-order read returns
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_rd,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic [DATA_W-1:0] o_req_rdata,
    output logic              o_req_done,
    output logic              o_req_stall,
    output logic              o_cache_hit,
    output logic              o_err,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_stall,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rvalid
);

    localparam logic [CNT_W-1:0]    LW_CNT   = CNT_W'(LINE_WORDS);
    localparam logic [OFF_BITS-1:0] LAST_OFF = OFF_BITS'(LINE_WORDS - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    req_t                r_req;
    logic [OFF_BITS-1:0] r_issue;
    logic [CNT_W-1:0]    r_ret;

    logic [WADDR_W-1:0]  w_live_wa;
    logic                w_req_any;
    logic                w_req_err;
    logic                w_lookup_hit;
    logic                w_start_miss;
    logic                w_issue_acc;
    logic                w_ret_acc;

    logic                w_done, w_hit, w_err, w_stall;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_mem_rd, w_mem_wr;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    logic [IDX_BITS-1:0] w_idx;
    logic [OFF_BITS-1:0] w_rd_off;
    logic [DATA_W-1:0]   w_rd_data;
    logic [TAG_BITS-1:0] w_rd_tag;
    logic                w_rd_valid, w_rd_dirty;
    logic [OFF_BITS-1:0] w_wr_off;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_wr_data_en, w_wr_meta_en;
    logic [TAG_BITS-1:0] w_wr_tag;
    logic                w_wr_valid, w_wr_dirty;

    assign w_live_wa = i_req_addr[ADDR_W-1:1];
    assign w_req_any = i_req_rd | i_req_wr;
    assign w_req_err = w_req_any & ((i_req_rd & i_req_wr) | i_req_addr[0]);

    // In IDLE the array is addressed by the live request; afterwards by the latched one.
    // During WB the read offset walks the victim line with the issue counter.
    assign w_idx    = (r_state == ST_IDLE) ? wa_idx(w_live_wa) : wa_idx(r_req.waddr);
    assign w_rd_off = (r_state == ST_IDLE) ? wa_off(w_live_wa) :
                      (r_state == ST_WB)   ? r_issue : wa_off(r_req.waddr);

    assign w_lookup_hit = w_rd_valid & (w_rd_tag == wa_tag(w_live_wa));

    dcache_array u_array (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rd_idx     (w_idx),
        .i_rd_off     (w_rd_off),
        .o_rd_data    (w_rd_data),
        .o_rd_tag     (w_rd_tag),
        .o_rd_valid   (w_rd_valid),
        .o_rd_dirty   (w_rd_dirty),
        .i_wr_idx     (w_idx),
        .i_wr_off     (w_wr_off),
        .i_wr_data    (w_wr_data),
        .i_wr_data_en (w_wr_data_en & ~i_rst),
        .i_wr_meta_en (w_wr_meta_en & ~i_rst),
        .i_wr_tag     (w_wr_tag),
        .i_wr_valid   (w_wr_valid),
        .i_wr_dirty   (w_wr_dirty)
    );

    // FSM next state, handshake outputs and array write controls.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_hit        = 1'b0;
        w_err        = 1'b0;
        w_stall      = 1'b0;
        w_rdata      = '0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_start_miss = 1'b0;
        w_issue_acc  = 1'b0;
        w_ret_acc    = 1'b0;
        w_wr_off     = wa_off(r_req.waddr);
        w_wr_data    = '0;
        w_wr_data_en = 1'b0;
        w_wr_meta_en = 1'b0;
        w_wr_tag     = w_rd_tag;
        w_wr_valid   = 1'b0;
        w_wr_dirty   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wr_off = wa_off(w_live_wa);
                if (!w_req_any) begin
                    w_next_state = ST_IDLE;
                end else if (w_req_err) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end else if (w_lookup_hit) begin
                    w_done = 1'b1;
                    w_hit  = 1'b1;
                    if (i_req_wr) begin
                        w_wr_data    = i_req_wdata;
                        w_wr_data_en = 1'b1;
                        w_wr_meta_en = 1'b1;
                        w_wr_valid   = 1'b1;
                        w_wr_dirty   = 1'b1;
                    end else begin
                        w_rdata = w_rd_data;
                    end
                end else begin
                    w_stall      = 1'b1;
                    w_start_miss = 1'b1;
                    if (w_rd_valid & w_rd_dirty) begin
                        w_next_state = ST_WB;
                    end else begin
                        // Drop the clean victim now so a half-filled line never looks valid.
                        w_next_state = ST_ALLOC;
                        w_wr_meta_en = 1'b1;
                    end
                end
            end
            ST_WB: begin
                w_stall     = 1'b1;
                w_mem_wr    = 1'b1;
                w_mem_addr  = line_word_addr(w_rd_tag, w_idx, r_issue);
                w_mem_wdata = w_rd_data;
                w_issue_acc = ~i_mem_stall;
                if (!i_mem_stall && (r_issue == LAST_OFF)) begin
                    w_next_state = ST_ALLOC;
                    w_wr_meta_en = 1'b1;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_ALLOC: begin
                w_stall     = 1'b1;
                w_mem_rd    = 1'b1;
                w_mem_addr  = line_word_addr(wa_tag(r_req.waddr), w_idx, r_issue);
                w_issue_acc = ~i_mem_stall;
                w_ret_acc   = i_mem_rvalid & (r_ret != LW_CNT);
                w_wr_off     = r_ret[OFF_BITS-1:0];
                w_wr_data    = i_mem_rdata;
                w_wr_data_en = w_ret_acc;
                if (!i_mem_stall && (r_issue == LAST_OFF)) begin
                    w_next_state = ST_FILL;
                end else begin
                    w_next_state = ST_ALLOC;
                end
            end
            ST_FILL: begin
                w_stall = 1'b1;
                if (r_ret == LW_CNT) begin
                    w_next_state = ST_DONE;
                    w_wr_meta_en = 1'b1;
                    w_wr_tag     = wa_tag(r_req.waddr);
                    w_wr_valid   = 1'b1;
                end else begin
                    w_ret_acc    = i_mem_rvalid;
                    w_wr_off     = r_ret[OFF_BITS-1:0];
                    w_wr_data    = i_mem_rdata;
                    w_wr_data_en = i_mem_rvalid;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
                if (r_req.wr) begin
                    w_wr_data    = r_req.wdata;
                    w_wr_data_en = 1'b1;
                    w_wr_meta_en = 1'b1;
                    w_wr_tag     = wa_tag(r_req.waddr);
                    w_wr_valid   = 1'b1;
                    w_wr_dirty   = 1'b1;
                end else begin
                    w_rdata = w_rd_data;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, request latch and issue/return counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_issue <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_miss) begin
                r_req.rd    <= i_req_rd;
                r_req.wr    <= i_req_wr;
                r_req.waddr <= w_live_wa;
                r_req.wdata <= i_req_wdata;
                r_issue     <= '0;
                r_ret       <= '0;
            end else begin
                // Issue counter wraps to 0 after the last word, ready for ALLOC.
                if (w_issue_acc) begin
                    r_issue <= r_issue + OFF_BITS'(1);
                end
                if (w_ret_acc) begin
                    r_ret <= r_ret + CNT_W'(1);
                end
            end
        end
    end

    // Everything is forced low while reset is asserted.
    assign o_req_done  = w_done   & ~i_rst;
    assign o_cache_hit = w_hit    & ~i_rst;
    assign o_err       = w_err    & ~i_rst;
    assign o_req_stall = w_stall  & ~i_rst;
    assign o_mem_rd    = w_mem_rd & ~i_rst;
    assign o_mem_wr    = w_mem_wr & ~i_rst;
    assign o_req_rdata = i_rst ? '0 : w_rdata;
    assign o_mem_addr  = i_rst ? '0 : w_mem_addr;
    assign o_mem_wdata = i_rst ? '0 : w_mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [15:0] req_addr, req_wdata, req_rdata;
    logic        req_done, req_stall, cache_hit, err;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_stall, mem_rvalid;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_rd     (req_rd),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_req_rdata  (req_rdata),
        .o_req_done   (req_done),
        .o_req_stall  (req_stall),
        .o_cache_hit  (cache_hit),
        .o_err        (err),
        .o_mem_rd     (mem_rd),
        .o_mem_wr     (mem_wr),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_stall  (mem_stall),
        .i_mem_rdata  (mem_rdata),
        .i_mem_rvalid (mem_rvalid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- main memory model ----------------
    function automatic logic [15:0] init_val(input int w);
        return 16'((w * 7) ^ 32'h0000A55A);
    endfunction

    typedef struct {
        logic [15:0] data;
        int          due;
    } ret_t;

    logic [15:0] mem [0:32767];
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    ret_t        rq[$];
    int cyc = 0, n_rd = 0, n_wr = 0, n_ret = 0, last_ret_cyc = 0;
    int lat = 1, stall_at_wr = -1, stall_left = 0, viol = 0;
    logic        prev_stalled, prev_rd, prev_wr;
    logic [15:0] prev_addr, prev_wdata;

    initial begin
        ret_t r;
        mem_stall = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000; prev_stalled = 1'b0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = 16'h0000; prev_wdata = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                rq.delete();
                mem_stall = 1'b0; mem_rvalid = 1'b0; prev_stalled = 1'b0;
            end else begin
                if (prev_stalled && (mem_rd !== prev_rd || mem_wr !== prev_wr ||
                    mem_addr !== prev_addr || (prev_wr && mem_wdata !== prev_wdata)))
                    viol++;
                mem_stall = (stall_left > 0) && mem_wr && (n_wr == stall_at_wr);
                if (mem_stall) stall_left--;
                if (mem_rd && !mem_stall) begin
                    rd_log.push_back(mem_addr);
                    r.data = mem[mem_addr[15:1]];
                    r.due  = cyc + lat;
                    rq.push_back(r);
                    n_rd++;
                end
                if (mem_wr && !mem_stall) begin
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                    mem[mem_addr[15:1]] = mem_wdata;
                    n_wr++;
                end
                prev_stalled = mem_stall && (mem_rd || mem_wr);
                prev_rd = mem_rd; prev_wr = mem_wr; prev_addr = mem_addr; prev_wdata = mem_wdata;
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rq[0].data;
                    void'(rq.pop_front());
                    n_ret++;
                    last_ret_cyc = cyc;
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = 16'h0000;
                end
            end
        end
    end

    // Handshake invariants sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (req_done && req_stall) viol++;
                if (!req_done && (cache_hit || err)) viol++;
                if (mem_rd && mem_wr) viol++;
            end
        end
    end

    // One access; starts just after a negedge and returns just after a later negedge.
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input string name,
                          output logic [15:0] rdata, output logic hit, output logic er,
                          output int waits, output int done_cyc);
        bit got = 1'b0;
        int n = 0;
        rdata = 16'h0000; hit = 1'b0; er = 1'b0; done_cyc = 0;
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        while (!got && n < 200) begin
            #2;
            if (req_done) begin
                got = 1'b1; rdata = req_rdata; hit = cache_hit; er = err; done_cyc = cyc;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        waits = n;
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [15:0] addr, wdata;
        logic [3:0]  exp_flags;   // {done, hit, err, stall}
        logic [15:0] exp_rdata;
        logic        chk_rdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [3:0] fl,
                                input logic [15:0] rdv, input logic chk);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_flags = fl; v.exp_rdata = rdv; v.chk_rdata = chk;
        return v;
    endfunction

    initial begin
        vec_t vecs[12];
        logic [15:0] rdv;
        logic hit, er;
        int waits, dcyc, b_rd, b_wr, b_ret, n;

        rst = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0000;

        // ---- reset: outputs low even with a request present ----
        @(negedge clk); #2;
        check("rst done", 32'(req_done), 32'd0);
        check("rst stall", 32'(req_stall), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_rd = 1'b0;
        @(negedge clk);

        // ---- 1: cold read miss of 0x0010 ----
        b_rd = n_rd; b_wr = n_wr;
        access(1'b1, 1'b0, 16'h0010, 16'h0000, "miss0010", rdv, hit, er, waits, dcyc);
        check("miss0010 rdata", 32'(rdv), 32'(init_val(16'h0008)));
        check("miss0010 hit", 32'(hit), 32'd0);
        check("miss0010 reads", 32'(n_rd - b_rd), 32'd4);
        check("miss0010 writes", 32'(n_wr - b_wr), 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("miss0010 rd_addr%0d", i), 32'(rd_log[b_rd + i]), 32'h10 + 32'(2 * i));

        // ---- table: hits, store hit, errors, idle ----
        vecs[0]  = mk(1'b1, 1'b0, 16'h0014, 16'h0000, 4'b1100, init_val(16'h000A), 1'b1);
        vecs[1]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 4'b1100, init_val(16'h0008), 1'b1);
        vecs[2]  = mk(1'b1, 1'b0, 16'h0016, 16'h0000, 4'b1100, init_val(16'h000B), 1'b1);
        vecs[3]  = mk(1'b0, 1'b1, 16'h0012, 16'hBEEF, 4'b1100, 16'h0000, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 16'h0012, 16'h0000, 4'b1100, 16'hBEEF, 1'b1);
        vecs[5]  = mk(1'b1, 1'b0, 16'h0013, 16'h0000, 4'b1010, 16'h0000, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 16'h0020, 16'h1111, 4'b1010, 16'h0000, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 16'h0011, 16'h2222, 4'b1010, 16'h0000, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 16'h0012, 16'h3333, 4'b1010, 16'h0000, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 16'h0017, 16'h0000, 4'b1010, 16'h0000, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 16'h0012, 16'h0000, 4'b0000, 16'h0000, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 16'h0012, 16'h0000, 4'b1100, 16'hBEEF, 1'b1);
        b_rd = n_rd; b_wr = n_wr;
        for (int i = 0; i < 12; i++) begin
            req_rd = vecs[i].rd; req_wr = vecs[i].wr;
            req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
            #2;
            check($sformatf("vec%0d flags", i), 32'({req_done, cache_hit, err, req_stall}),
                  32'(vecs[i].exp_flags));
            if (vecs[i].chk_rdata)
                check($sformatf("vec%0d rdata", i), 32'(req_rdata), 32'(vecs[i].exp_rdata));
            @(negedge clk);
        end
        req_rd = 1'b0; req_wr = 1'b0;
        @(negedge clk);
        check("table mem traffic", 32'((n_rd - b_rd) + (n_wr - b_wr)), 32'd0);

        // ---- 4b: 0x0020 misses normally after the error ----
        b_rd = n_rd;
        access(1'b1, 1'b0, 16'h0020, 16'h0000, "miss0020", rdv, hit, er, waits, dcyc);
        check("miss0020 rdata", 32'(rdv), 32'(init_val(16'h0010)));
        check("miss0020 hit/err", 32'({hit, er}), 32'd0);
        check("miss0020 first rd", 32'(rd_log[b_rd]), 32'h0020);

        // ---- 2+3: dirty victim writeback with 3 stall cycles on the third write ----
        b_rd = n_rd; b_wr = n_wr;
        stall_at_wr = n_wr + 2; stall_left = 3;
        access(1'b1, 1'b0, 16'h0112, 16'h0000, "wb0112", rdv, hit, er, waits, dcyc);
        check("wb0112 rdata", 32'(rdv), 32'(init_val(16'h0089)));
        check("wb0112 hit", 32'(hit), 32'd0);
        check("wb0112 writes", 32'(n_wr - b_wr), 32'd4);
        check("wb0112 stalls used", 32'(stall_left), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wb0112 wr_addr%0d", i), 32'(wr_addr_log[b_wr + i]), 32'h10 + 32'(2 * i));
            check($sformatf("wb0112 rd_addr%0d", i), 32'(rd_log[b_rd + i]), 32'h110 + 32'(2 * i));
        end
        check("wb0112 wr_data0", 32'(wr_data_log[b_wr + 0]), 32'(init_val(16'h0008)));
        check("wb0112 wr_data1", 32'(wr_data_log[b_wr + 1]), 32'hBEEF);
        check("wb0112 wr_data2", 32'(wr_data_log[b_wr + 2]), 32'(init_val(16'h000A)));
        check("wb0112 wr_data3", 32'(wr_data_log[b_wr + 3]), 32'(init_val(16'h000B)));

        // Written-back data comes back from memory; clean victim means no writeback.
        b_wr = n_wr;
        access(1'b1, 1'b0, 16'h0012, 16'h0000, "refetch0012", rdv, hit, er, waits, dcyc);
        check("refetch0012 rdata", 32'(rdv), 32'hBEEF);
        check("refetch0012 writes", 32'(n_wr - b_wr), 32'd0);

        // Store miss allocates, then a load hits with zero wait.
        access(1'b0, 1'b1, 16'h0034, 16'h1234, "stmiss0034", rdv, hit, er, waits, dcyc);
        check("stmiss0034 hit", 32'(hit), 32'd0);
        access(1'b1, 1'b0, 16'h0034, 16'h0000, "ld0034", rdv, hit, er, waits, dcyc);
        check("ld0034 hit", 32'(hit), 32'd1);
        check("ld0034 waits", 32'(waits), 32'd0);
        check("ld0034 rdata", 32'(rdv), 32'h1234);

        // ---- 6: slow returns; DONE two cycles after the last return ----
        lat = 3; b_ret = n_ret;
        access(1'b1, 1'b0, 16'h0040, 16'h0000, "slow0040", rdv, hit, er, waits, dcyc);
        check("slow0040 rdata", 32'(rdv), 32'(init_val(16'h0020)));
        check("slow0040 returns", 32'(n_ret - b_ret), 32'd4);
        check("slow0040 done gap", 32'(dcyc - last_ret_cyc), 32'd2);
        lat = 1;

        // ---- 5: reset after two fill returns ----
        b_ret = n_ret;
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h0050;
        n = 0;
        #2;
        while ((n_ret - b_ret) < 2 && n < 50) begin
            @(negedge clk); #2; n++;
        end
        check("rst5 two returns", 32'(n_ret - b_ret >= 2), 32'd1);
        rst = 1'b1; req_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst5 stall", 32'(req_stall), 32'd0);
        check("rst5 mem_rd", 32'(mem_rd), 32'd0);
        check("rst5 done", 32'(req_done), 32'd0);
        repeat (4) @(negedge clk);
        b_rd = n_rd;
        access(1'b1, 1'b0, 16'h0050, 16'h0000, "reread0050", rdv, hit, er, waits, dcyc);
        check("reread0050 hit", 32'(hit), 32'd0);
        check("reread0050 reads", 32'(n_rd - b_rd), 32'd4);
        check("reread0050 rdata", 32'(rdv), 32'(init_val(16'h0028)));

        repeat (2) @(negedge clk);
        check("protocol violations", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
